// File: rtl/pll1_lock_supervisor.sv
// pll1_lock_supervisor: PLL reset sequencer and lock supervisor on refclk.
// Drives the PLL reset, waits for a synchronized lock, and retries on timeout.
// Downstream reset is held until lock has been stable for LOCK_STABLE_CYCLES.
// Optional macro PLL1_LOCK_SUPERVISOR_AUTORELOCK_EN: when it is defined, loss of
// lock in RUN restarts bring-up instead of latching FAIL.
module pll1_lock_supervisor #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 36000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 3600,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic       lol_pulse
);

    localparam int unsigned MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int          CNT_W  = $clog2(MAX_P) + 1;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle phase sees N-1.
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic             meta_q, meta_d;
    logic             locked_s_q, locked_s_d;
    logic             lol_pulse_q, lol_pulse_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    // Next-state, counter and retry logic; outputs are decoded from the next
    // state so they come straight out of flops with no decode glitches.
    always_comb begin
        meta_d      = locked;
        locked_s_d  = meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_cnt_d = retry_cnt_q;
        lol_pulse_d = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_cnt_q < RETRY_MAX) begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        state_d     = S_RESET_PLL;
                    end else begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_STABLE: begin
                // A lock dropout restarts the timeout without spending a retry.
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ST_LAST) begin
                    state_d     = S_RUN;
                    cnt_d       = '0;
                    retry_cnt_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s_q) begin
                    lol_pulse_d = 1'b1;
`ifdef PLL1_LOCK_SUPERVISOR_AUTORELOCK_EN
                    state_d     = S_RESET_PLL;
                    retry_cnt_d = '0;
`else
                    state_d     = S_FAIL;
`endif
                end
            end
            S_FAIL: begin
                cnt_d = cnt_q;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d = (state_d == S_RESET_PLL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    // State, synchronizer and registered outputs; rst restarts bring-up.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            retry_cnt_q <= '0;
            meta_q      <= 1'b0;
            locked_s_q  <= 1'b0;
            lol_pulse_q <= 1'b0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_cnt_q <= retry_cnt_d;
            meta_q      <= meta_d;
            locked_s_q  <= locked_s_d;
            lol_pulse_q <= lol_pulse_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_cnt_q;
    assign lol_pulse = lol_pulse_q;

endmodule

// File: tb/tb_pll1_lock_supervisor.sv
// Directed bench for pll1_lock_supervisor with small timing parameters
// (PLL_RST=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2). Edge numbers in the
// comments count rising edges after the first edge that samples rst=0.
module tb_pll1_lock_supervisor;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fail, lol_pulse;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    pll1_lock_supervisor #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .lol_pulse(lol_pulse)
    );

    always #5 refclk = ~refclk;

    // Observed outputs packed as {pll_rst, sys_rst, ready, fail, retry_cnt, lol_pulse}.
    logic [8:0] obs;
    assign obs = {pll_rst, sys_rst, ready, fail, retry_cnt, lol_pulse};

    typedef struct {
        logic       rst;
        logic       locked;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [8:0] pk(input logic p, input logic s, input logic r,
                                      input logic f, input logic [3:0] rc, input logic l);
        return {p, s, r, f, rc, l};
    endfunction

    // Present inputs, then sample 1 time unit after the next rising edge.
    task automatic cyc(input logic r, input logic l);
        rst    = r;
        locked = l;
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [8:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pll_rst,sys_rst,ready,fail,retry[3:0],lol)",
                     nm, obs, exp);
        end
    endtask

    task automatic apply_clean(input string tag);
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst, tbl[i].locked);
            chk($sformatf("%s_clean[%0d]", tag, i), tbl[i].exp);
        end
    endtask

    initial begin
        // Clean-lock table: two reset cycles, then edges 1..14 with locked=1.
        tbl[0] = '{1'b1, 1'b1, pk(1, 1, 0, 0, 4'd0, 0)};
        tbl[1] = '{1'b1, 1'b1, pk(1, 1, 0, 0, 4'd0, 0)};
        for (int i = 2; i < 16; i++) begin
            tbl[i].rst    = 1'b0;
            tbl[i].locked = 1'b1;
            if (i <= 4)       tbl[i].exp = pk(1, 1, 0, 0, 4'd0, 0); // edges 1-3 RESET_PLL
            else if (i <= 13) tbl[i].exp = pk(0, 1, 0, 0, 4'd0, 0); // edges 4-12 WAIT/STABLE
            else              tbl[i].exp = pk(0, 0, 1, 0, 4'd0, 0); // edges 13-14 RUN
        end

        // Clean lock, then loss of lock in RUN.
        apply_clean("t1");
        cyc(1'b0, 1'b1);
        chk("run_e15", pk(0, 0, 1, 0, 4'd0, 0));
        cyc(1'b0, 1'b0);
        chk("lol_e16", pk(0, 0, 1, 0, 4'd0, 0));
        cyc(1'b0, 1'b0);
        chk("lol_e17", pk(0, 0, 1, 0, 4'd0, 0));
        cyc(1'b0, 1'b0);
`ifdef PLL1_LOCK_SUPERVISOR_AUTORELOCK_EN
        chk("lol_e18", pk(1, 1, 0, 0, 4'd0, 1));
        for (int e = 19; e <= 22; e++) begin
            cyc(1'b0, 1'b0);
            chk($sformatf("relock_e%0d", e), pk(e <= 21, 1, 0, 0, 4'd0, 0));
        end
`else
        chk("lol_e18", pk(0, 1, 0, 1, 4'd0, 1));
        for (int e = 19; e <= 22; e++) begin
            cyc(1'b0, 1'b0);
            chk($sformatf("lolfail_e%0d", e), pk(0, 1, 0, 1, 4'd0, 0));
        end
`endif

        // No lock ever: pulses at edges 0/24/48, FAIL from edge 72.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("nolock_rst", pk(1, 1, 0, 0, 4'd0, 0));
        for (int e = 1; e <= 80; e++) begin
            logic [3:0] rc;
            rc = (e < 24) ? 4'd0 : (e < 48) ? 4'd1 : 4'd2;
            cyc(1'b0, 1'b0);
            chk($sformatf("nolock_e%0d", e), pk((e < 72) && (e % 24 < 4), 1, 0, e >= 72, rc, 0));
        end

        // Reset while in FAIL, then the clean sequence again.
        cyc(1'b1, 1'b1);
        chk("rst_in_fail", pk(1, 1, 0, 0, 4'd0, 0));
        apply_clean("t2");

        // locked low for 3 cycles during STABLE (edges 8-10).
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int e = 1; e <= 21; e++) begin
            cyc(1'b0, !(e >= 8 && e <= 10));
            if (e == 10) chk("glitch_e10_wait", pk(0, 1, 0, 0, 4'd0, 0));
            if (e == 12) chk("glitch_e12_wait", pk(0, 1, 0, 0, 4'd0, 0));
            if (e == 13) chk("glitch_e13_stable", pk(0, 1, 0, 0, 4'd0, 0));
            if (e == 20) chk("glitch_e20_notrun", pk(0, 1, 0, 0, 4'd0, 0));
            if (e == 21) chk("glitch_e21_run", pk(0, 0, 1, 0, 4'd0, 0));
        end

        // Lock arriving on the last WAIT_LOCK cycle of the second attempt.
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        for (int e = 1; e <= 56; e++) begin
            cyc(1'b0, e >= 46);
            if (e == 24) chk("tmo_e24_retry", pk(1, 1, 0, 0, 4'd1, 0));
            if (e == 47) chk("tmo_e47_wait", pk(0, 1, 0, 0, 4'd1, 0));
            if (e == 48) chk("tmo_e48_stable", pk(0, 1, 0, 0, 4'd1, 0));
            if (e == 55) chk("tmo_e55_stable", pk(0, 1, 0, 0, 4'd1, 0));
            if (e == 56) chk("tmo_e56_run", pk(0, 0, 1, 0, 4'd0, 0));
        end

        // Reset while in STABLE, then the clean sequence again.
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        for (int e = 1; e <= 8; e++) cyc(1'b0, 1'b1);
        chk("stable_e8", pk(0, 1, 0, 0, 4'd0, 0));
        cyc(1'b1, 1'b1);
        chk("rst_in_stable", pk(1, 1, 0, 0, 4'd0, 0));
        apply_clean("t3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
